// File: rtl/usbf_dma_arb_pkg.sv
// Shared definitions for the USB function DMA arbiter: FSM encodings and default burst length.
package usbf_dma_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } dma_state_t;

   localparam int USBF_MAX_BURST = 8;

endpackage

// File: rtl/usbf_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr, wrapping modulo NEP.
module usbf_rr_pick #(
   parameter int NEP = 4
) (
   input  logic [NEP-1:0]         eligible,
   input  logic [$clog2(NEP)-1:0] ptr,
   output logic [$clog2(NEP)-1:0] index,
   output logic                   valid
);

   localparam int IW = $clog2(NEP);

   int pos;

   // Walk from the farthest offset down so the nearest eligible slot wins.
   always_comb begin
      index = '0;
      valid = |eligible;
      pos   = 0;
      for (int k = NEP - 1; k >= 0; k--) begin
         pos = (int'(ptr) + k) % NEP;
         if (eligible[pos[IW-1:0]]) index = pos[IW-1:0];
      end
   end

endmodule

// File: rtl/usbf_dma_arb.sv
// Round-robin arbiter sharing one external DMA channel among NEP endpoint register files.
module usbf_dma_arb
   import usbf_dma_arb_pkg::*;
#(
   parameter int NEP       = 4,
   parameter int MAX_BURST = USBF_MAX_BURST
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NEP-1:0]         ep_en,
   input  logic [NEP-1:0]         ep_dma_req,
   output logic [NEP-1:0]         ep_dma_ack,
   output logic                   dma_req,
   input  logic                   dma_ack,
   output logic [$clog2(NEP)-1:0] dma_ep,
   output logic                   dma_busy,
   output logic                   ack_err
);

   localparam int IW = $clog2(NEP);

   dma_state_t     state;
   dma_state_t     state_nxt;
   logic [IW-1:0]  grant;
   logic [IW-1:0]  rr_ptr;
   logic [IW-1:0]  pick_idx;
   logic           pick_vld;
   logic [7:0]     burst_cnt;
   logic [NEP-1:0] eligible;
   logic           grant_live;
   logic           last_beat;

   assign eligible   = ep_dma_req & ep_en;
   assign grant_live = ep_dma_req[grant] & ep_en[grant];
   assign last_beat  = dma_ack & (burst_cnt == 8'(MAX_BURST - 1));

   usbf_rr_pick #(.NEP(NEP)) u_pick (
      .eligible (eligible),
      .ptr      (rr_ptr),
      .index    (pick_idx),
      .valid    (pick_vld)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (pick_vld) state_nxt = ST_BUSY;
         ST_BUSY:    if (!grant_live || last_beat) state_nxt = ST_RELEASE;
         ST_RELEASE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Acks are forwarded only while a grant is held, even if the request drops that cycle.
   always_comb begin
      dma_busy   = (state == ST_BUSY);
      dma_req    = dma_busy & grant_live;
      dma_ep     = grant;
      ep_dma_ack = '0;
      if (dma_busy) ep_dma_ack[grant] = dma_ack;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         ack_err   <= 1'b0;
      end else begin
         ack_err <= dma_ack & (state != ST_BUSY);
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  grant     <= pick_idx;
                  burst_cnt <= '0;
               end
            end
            ST_BUSY: begin
               if (dma_ack) burst_cnt <= burst_cnt + 8'd1;
            end
            ST_RELEASE: begin
               rr_ptr <= (grant == IW'(NEP - 1)) ? '0 : grant + IW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Directed bench for usbf_dma_arb (NEP=4, MAX_BURST=8); inputs change on the falling edge.
module tb_usbf_dma_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] ep_en;
   logic [3:0] ep_dma_req;
   logic [3:0] ep_dma_ack;
   logic       dma_req;
   logic       dma_ack;
   logic [1:0] dma_ep;
   logic       dma_busy;
   logic       ack_err;

   int checks = 0;
   int errors = 0;

   usbf_dma_arb #(.NEP(4), .MAX_BURST(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ep_en      (ep_en),
      .ep_dma_req (ep_dma_req),
      .ep_dma_ack (ep_dma_ack),
      .dma_req    (dma_req),
      .dma_ack    (dma_ack),
      .dma_ep     (dma_ep),
      .dma_busy   (dma_busy),
      .ack_err    (ack_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_busy(input string tag, input logic [1:0] ep);
      chk({tag, "_busy"}, 32'(dma_busy), 32'd1);
      chk({tag, "_ep"}, 32'(dma_ep), 32'(ep));
      chk({tag, "_ack"}, 32'(ep_dma_ack), 32'(4'b0001 << ep));
   endtask

   task automatic chk_gap(input string tag);
      chk({tag, "_busy"}, 32'(dma_busy), 32'd0);
      chk({tag, "_req"}, 32'(dma_req), 32'd0);
      chk({tag, "_ack"}, 32'(ep_dma_ack), 32'd0);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int g;
      // Reset state
      rst = 1'b0; ep_en = '0; ep_dma_req = '0; dma_ack = 1'b0;
      #2;
      chk_gap("rst0");
      chk("rst0_ep", 32'(dma_ep), 32'd0);
      chk("rst0_err", 32'(ack_err), 32'd0);
      tick(); rst = 1'b1;

      // Single endpoint with continuous acks: one 8-beat burst, 2-cycle gap, re-grant
      tick(); ep_en = 4'hF; ep_dma_req = 4'b0100; dma_ack = 1'b1; #1;
      chk_gap("s1_idle");
      for (int i = 0; i < 8; i++) begin tick(); #1; chk_busy("s1_beat", 2'd2); end
      tick(); #1; chk_gap("s1_rel");
      chk("s1_rel_err", 32'(ack_err), 32'd0);
      tick(); #1; chk_gap("s1_idle2");
      chk("s1_idle2_err", 32'(ack_err), 32'd1);
      tick(); #1; chk_busy("s1_regrant", 2'd2);
      tick(); ep_dma_req = '0; dma_ack = 1'b0; #1;
      chk("s1_drop_req", 32'(dma_req), 32'd0);
      chk("s1_drop_busy", 32'(dma_busy), 32'd1);
      tick(); #1; chk_gap("s1_drop_rel");
      tick(); #1; chk_gap("s1_drop_idle");

      // All endpoints requesting from a fresh pointer: 0,1,2,3,0
      tick(); rst = 1'b0;
      tick(); rst = 1'b1; ep_dma_req = 4'hF; dma_ack = 1'b1; #1;
      chk_gap("s2_idle");
      for (int n = 0; n < 5; n++) begin
         g = n % 4;
         for (int i = 0; i < 8; i++) begin tick(); #1; chk_busy("s2_beat", 2'(g)); end
         for (int i = 0; i < 2; i++) begin tick(); #1; chk_gap("s2_gap"); end
      end
      ep_dma_req = '0; dma_ack = 1'b0;

      // Request drop after 3 acks on ep 1, then ep 2/3 served before ep 0
      tick(); ep_dma_req = 4'b0011; dma_ack = 1'b1; #1;
      chk_gap("s3_idle");
      for (int i = 0; i < 3; i++) begin tick(); #1; chk_busy("s3_beat", 2'd1); end
      tick(); ep_dma_req = 4'b0001; dma_ack = 1'b0; #1;
      chk("s3_drop_req", 32'(dma_req), 32'd0);
      chk("s3_drop_busy", 32'(dma_busy), 32'd1);
      tick(); ep_dma_req = 4'b1101; #1; chk_gap("s3_rel");
      tick(); #1; chk_gap("s3_idle2");
      tick(); dma_ack = 1'b1; ep_dma_req = 4'b1001; #1;
      chk_busy("s3_ep2_ackdrop", 2'd2);
      chk("s3_ackdrop_req", 32'(dma_req), 32'd0);
      tick(); dma_ack = 1'b0; #1; chk_gap("s3_rel2");
      tick(); #1; chk_gap("s3_idle3");
      tick(); ep_dma_req = '0; #1;
      chk("s3_ep3_busy", 32'(dma_busy), 32'd1);
      chk("s3_ep3_ep", 32'(dma_ep), 32'd3);
      tick(); #1; chk_gap("s3_rel3");
      tick(); #1; chk_gap("s3_idle4");

      // Disabled endpoint never granted; enable cleared mid-grant
      tick(); ep_en = 4'b0111; ep_dma_req = 4'b1000; #1;
      for (int i = 0; i < 3; i++) begin tick(); #1; chk_gap("s4_masked"); end
      tick(); ep_dma_req = 4'b1001; #1; chk_gap("s4_idle");
      tick(); #1;
      chk("s4_busy", 32'(dma_busy), 32'd1);
      chk("s4_ep", 32'(dma_ep), 32'd0);
      chk("s4_req", 32'(dma_req), 32'd1);
      tick(); ep_en = 4'b0110; #1;
      chk("s4_en_drop_req", 32'(dma_req), 32'd0);
      chk("s4_en_drop_busy", 32'(dma_busy), 32'd1);
      tick(); #1; chk_gap("s4_rel");
      tick(); #1; chk_gap("s4_none");
      ep_dma_req = '0; ep_en = 4'hF;

      // Stray ack in IDLE
      tick(); dma_ack = 1'b1; #1;
      chk("s5_fwd", 32'(ep_dma_ack), 32'd0);
      chk("s5_err_pre", 32'(ack_err), 32'd0);
      tick(); dma_ack = 1'b0; #1;
      chk("s5_err", 32'(ack_err), 32'd1);
      tick(); #1;
      chk("s5_err_clr", 32'(ack_err), 32'd0);

      // Reset mid-burst, then fresh grant from pointer 0 with a full 8-beat burst
      tick(); ep_dma_req = 4'b0100; dma_ack = 1'b1; #1;
      chk_gap("s6_idle");
      for (int i = 0; i < 5; i++) begin tick(); #1; chk_busy("s6_beat", 2'd2); end
      tick(); rst = 1'b0; #1;
      chk_gap("s6_rst");
      chk("s6_rst_ep", 32'(dma_ep), 32'd0);
      chk("s6_rst_err", 32'(ack_err), 32'd0);
      tick(); rst = 1'b1; ep_dma_req = 4'b1000; #1;
      chk_gap("s6_post_rst");
      for (int i = 0; i < 8; i++) begin tick(); #1; chk_busy("s6_new", 2'd3); end
      tick(); #1; chk_gap("s6_rel");
      ep_dma_req = '0; dma_ack = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usbf_dma_arb.md
USBF_DMA_ARB -- requirements
Module: usbf_dma_arb

Interface
REQ-001 Parameter NEP, default 4, number of endpoint register files sharing the DMA channel (2..16).
REQ-002 Parameter MAX_BURST, default 8, maximum dma_ack beats per grant (1..255).
REQ-003 Port clk  input  1  core clock; one clock, all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port ep_en  input  NEP  per-endpoint DMA enable mask (csr dma_en of each register file).
REQ-006 Port ep_dma_req  input  NEP  DMA request from each endpoint register file.
REQ-007 Port ep_dma_ack  output  NEP  DMA acknowledge routed back to each endpoint register file.
REQ-008 Port dma_req  output  1  request to the single external DMA channel.
REQ-009 Port dma_ack  input  1  one-cycle acknowledge pulse from the external DMA channel, one per word.
REQ-010 Port dma_ep  output  clog2(NEP)  index of the endpoint currently granted.
REQ-011 Port dma_busy  output  1  high while a grant is held.
REQ-012 Port ack_err  output  1  one-cycle pulse: dma_ack received with no grant held.

Function
REQ-013 States SHALL be IDLE, BUSY and RELEASE, held in a registered state variable.
REQ-014 Eligible vector SHALL be ep_dma_req & ep_en.
REQ-015 IDLE: if any endpoint is eligible, the next state SHALL be BUSY, with grant set to the first eligible index at or after rr_ptr, searching upward modulo NEP; otherwise the block SHALL stay in IDLE.
REQ-016 dma_req SHALL equal (state==BUSY) & ep_dma_req[grant] & ep_en[grant], combinationally.
REQ-017 ep_dma_ack[i] SHALL equal dma_ack & (state==BUSY) & (grant==i), with zero latency; all other bits SHALL be 0.
REQ-018 dma_ep SHALL equal grant; dma_busy SHALL equal (state==BUSY).
REQ-019 burst_cnt (8 bit) SHALL clear on entry to BUSY and increment on each dma_ack accepted in BUSY.
REQ-020 BUSY SHALL go to RELEASE in any of these cases: dma_ack with burst_cnt==MAX_BURST-1; ep_dma_req[grant]==0; ep_en[grant]==0.
REQ-021 An ack and a request drop in the same cycle SHALL still be forwarded, and BUSY SHALL go to RELEASE.
REQ-022 RELEASE SHALL last exactly one cycle with dma_req=0, SHALL set rr_ptr to (grant+1) mod NEP, and SHALL return to IDLE.
REQ-023 The minimum gap between grants SHALL be 2 cycles (RELEASE, IDLE), which covers the endpoint ack synchronizer delay.
REQ-024 dma_ack in IDLE or RELEASE SHALL NOT be forwarded and SHALL pulse ack_err in the next cycle (registered).
REQ-025 Fairness: an endpoint that stays eligible SHALL be granted within NEP-1 intervening grants.
REQ-026 The grant index SHALL NOT change while in BUSY.

Reset
REQ-027 On rst low, asynchronously: state=IDLE, grant=0, rr_ptr=0, burst_cnt=0, ack_err=0.
REQ-028 Output values during reset: dma_req=0, ep_dma_ack=0, dma_busy=0, dma_ep=0.
REQ-029 Reset asserted mid-BUSY SHALL abort the grant immediately, and no ack SHALL be forwarded afterwards.

Structure
REQ-030 State encodings and the MAX_BURST default SHALL live in the shared usbf defines/package; NEP SHALL remain a module parameter.
REQ-031 The round-robin search SHALL be a sub-module, usbf_rr_pick (inputs eligible and ptr; outputs index and valid), purely combinational.
REQ-032 The block SHALL contain no other sub-modules and no memories.

Verification
REQ-033 Scenario: ep_en=4'hF, ep_dma_req=4'b0100 held, dma_ack every cycle -> BUSY with dma_ep=2; 8 acks reach ep_dma_ack[2]; then RELEASE, IDLE and re-grant to ep 2.
REQ-034 Scenario: ep_dma_req=4'hF held, MAX_BURST=8 -> grants in order 0,1,2,3,0, each of 8 beats, with a 2-cycle gap between grants.
REQ-035 Scenario: ep 1 granted, ep_dma_req[1] drops after 3 acks -> RELEASE next cycle and rr_ptr=2; ep 0 request waiting -> ep 2 or 3 served before ep 0 if eligible.
REQ-036 Scenario: ep_en[3]=0 while ep_dma_req[3]=1 -> ep 3 never granted; ep_en[grant] cleared in BUSY -> dma_req=0 the same cycle, RELEASE next cycle.
REQ-037 Scenario: dma_ack pulsed in IDLE -> ep_dma_ack stays 0 and ack_err=1 for exactly one cycle.
REQ-038 Scenario: rst asserted during BUSY after 5 acks -> all outputs 0 that cycle; after release with ep_dma_req=4'h8 -> grant to ep 3 (ptr=0, search upward), burst_cnt starts from 0.
